// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes and status out.
// Latency: wires only; timing is set by the controller that drives the outputs.
// Backpressure: carried as stage write enables (pc_write, *_write), not as a handshake.
//
// Signals (master = hazard controller, slave = pipeline datapath):
//   id_rs/id_rt/id_uses_rt/id_jump  ID-stage decode info
//   ex_valid/ex_mem_read/ex_rt       EX-stage load info
//   ex_branch_taken                  branch outcome resolved in EX
//   mem_req/mem_ready                data-memory request/completion in MEM
//   pc_write/pc_sel/*_write/*_flush  PC and pipeline-register controls
//   mem_wb_bubble                    MEM_WB loaded with a bubble
//   state/stall_count/mem_error      controller status
interface pipeline_hazard_controller_if #(
    parameter int COUNT_W = 16
);
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rt;
    logic               id_jump;
    logic               ex_valid;
    logic               ex_mem_read;
    logic [4:0]         ex_rt;
    logic               ex_branch_taken;
    logic               mem_req;
    logic               mem_ready;

    logic               pc_write;
    logic [1:0]         pc_sel;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_write;
    logic               id_ex_flush;
    logic               ex_mem_write;
    logic               mem_wb_bubble;
    logic [1:0]         state;
    logic [COUNT_W-1:0] stall_count;
    logic               mem_error;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_jump,
        input  ex_valid, ex_mem_read, ex_rt, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_write, pc_sel, if_id_write, if_id_flush,
        output id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble,
        output state, stall_count, mem_error
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_jump,
        output ex_valid, ex_mem_read, ex_rt, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_write, pc_sel, if_id_write, if_id_flush,
        input  id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble,
        input  state, stall_count, mem_error
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central hazard sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
// Latency: controls are combinational from registered state plus current inputs.
// Backpressure: stalls via pc_write/*_write low; memory waits freeze the whole pipe.
//
// Ports: clk, reset (synchronous, active-high) and hz (master modport of
// pipeline_hazard_controller_if) carrying decode/EX/MEM status in and the
// PC select/enable, stage write/flush strobes and status (state,
// stall_count, mem_error) out.
module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,   // bubbles per load-use hazard, 1..15
    parameter int MEM_TIMEOUT       = 64,  // wait cycles before mem_error, 2..65535
    parameter int COUNT_W           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    pipeline_hazard_controller_if.master   hz
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [3:0]  LU_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] TO_MAX  = 16'(MEM_TIMEOUT);

    localparam logic [1:0] SEL_PC1 = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;

    state_t             state_q, state_d;
    state_t             saved_q, saved_d;
    logic [3:0]         lu_cnt_q, lu_cnt_d;
    logic [15:0]        to_cnt_q, to_cnt_d;
    logic               mem_error_q, mem_error_d;
    logic [COUNT_W-1:0] stall_cnt_q;

    logic       pc_write_c;
    logic [1:0] pc_sel_c;
    logic       if_id_write_c, if_id_flush_c;
    logic       id_ex_write_c, id_ex_flush_c;
    logic       ex_mem_write_c, mem_wb_bubble_c;

    logic load_use;
    logic mem_wait;

    // $0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = hz.ex_valid && hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    assign mem_wait = hz.mem_req && !hz.mem_ready;

    always_comb begin
        // RUN defaults: everything advances, nothing flushed.
        pc_write_c      = 1'b1;
        pc_sel_c        = SEL_PC1;
        if_id_write_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_write_c   = 1'b1;
        id_ex_flush_c   = 1'b0;
        ex_mem_write_c  = 1'b1;
        mem_wb_bubble_c = 1'b0;

        state_d     = state_q;
        saved_d     = saved_q;
        lu_cnt_d    = lu_cnt_q;
        to_cnt_d    = to_cnt_q;
        mem_error_d = mem_error_q;

        if (reset) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            if_id_flush_c   = 1'b1;
            id_ex_write_c   = 1'b0;
            id_ex_flush_c   = 1'b1;
            ex_mem_write_c  = 1'b0;
            mem_wb_bubble_c = 1'b1;
        end else if (state_q == MEM_WAIT) begin
            if (mem_wait) begin
                pc_write_c      = 1'b0;
                if_id_write_c   = 1'b0;
                id_ex_write_c   = 1'b0;
                ex_mem_write_c  = 1'b0;
                mem_wb_bubble_c = 1'b1;
                if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
                if (to_cnt_q + 16'd1 == TO_MAX) begin
                    mem_error_d = 1'b1;
                end
            end else begin
                // Access completed (or request withdrawn): advance once with
                // default controls and resume whatever was interrupted.
                state_d  = saved_q;
                to_cnt_d = 16'd0;
            end
        end else if (mem_wait) begin
            // Entry cycle already counts as the first wait cycle.
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            id_ex_write_c   = 1'b0;
            ex_mem_write_c  = 1'b0;
            mem_wb_bubble_c = 1'b1;
            saved_d         = state_q;
            state_d         = MEM_WAIT;
            to_cnt_d        = 16'd1;
        end else if (hz.ex_branch_taken) begin
            // Taken branch squashes both younger instructions, including
            // the one a load-use stall was holding.
            pc_sel_c      = SEL_BR;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = RUN;
            lu_cnt_d      = 4'd0;
        end else if (state_q == LU_STALL) begin
            // Hazard term is not re-evaluated: the load has left EX.
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
            lu_cnt_d      = lu_cnt_q - 4'd1;
            if (lu_cnt_q <= 4'd1) begin
                state_d  = RUN;
                lu_cnt_d = 4'd0;
            end
        end else begin
            // RUN; also recovers the unencoded state value.
            state_d = RUN;
            if (load_use) begin
                // A jump in ID waits here and is seen again after the stall.
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_flush_c = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = LU_INIT;
                end
            end else if (hz.id_jump) begin
                pc_sel_c      = SEL_JMP;
                if_id_flush_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            lu_cnt_q    <= 4'd0;
            to_cnt_q    <= 16'd0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            lu_cnt_q    <= lu_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_error_q <= mem_error_d;
            if (!pc_write_c && (stall_cnt_q != {COUNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign hz.pc_write      = pc_write_c;
    assign hz.pc_sel        = pc_sel_c;
    assign hz.if_id_write   = if_id_write_c;
    assign hz.if_id_flush   = if_id_flush_c;
    assign hz.id_ex_write   = id_ex_write_c;
    assign hz.id_ex_flush   = id_ex_flush_c;
    assign hz.ex_mem_write  = ex_mem_write_c;
    assign hz.mem_wb_bubble = mem_wb_bubble_c;
    assign hz.state         = state_q;
    assign hz.stall_count   = stall_cnt_q;
    assign hz.mem_error     = mem_error_q;

endmodule
